// File: rtl/timer_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter_pkg
// Purpose  : Shared constants for the memory-mapped down-counting timer.
//            Provides the register word offsets, the mode encodings, the
//            CTRL field layout, the FSM state encoding and the bus base
//            address of the timer slot.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef TC_BASE
`define TC_BASE 32'h0000_7F00
`endif

package timer_counter_pkg;

  // Register word offsets (DEV_ADDR[4:2])
  localparam logic [2:0] TC_CTRL   = 3'd0;
  localparam logic [2:0] TC_PRESET = 3'd1;
  localparam logic [2:0] TC_COUNT  = 3'd2;
  localparam logic [2:0] TC_STATUS = 3'd3;

  // Mode encodings; 2'b10 and 2'b11 fall back to one-shot
  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  // CTRL register layout (bits [3:0]; [31:4] always read as zero)
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Purpose  : Down-counting timer responder on the CPU device bus. Counts
//            PRESET down to zero, then raises a level interrupt; supports
//            one-shot and auto-reload modes.
// Ports    : clk   - system clock, rising-edge
//            reset - synchronous active-high reset
//            Addr  - register word offset [2:0]
//            WE    - write strobe, sampled on the clock edge
//            DIN   - 32-bit write data
//            DOUT  - 32-bit read data, combinational from Addr
//            IRQ   - interrupt request (pending & CTRL.IM)
// Config   : TIMER_IRQ_STATUS_EN - when defined, offset 3 is a STATUS
//            register reading {31'b0, irq_pend}; any write to it clears
//            the pending interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  tc_ctrl_t    ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_pend_q, irq_pend_d;
  tc_state_e   state_q, state_d;

  logic wr_ctrl;
  logic wr_preset;
  logic reload_mode;
  logic irq_set;
  logic irq_clr;

  assign wr_ctrl   = WE && (Addr == TC_CTRL);
  assign wr_preset = WE && (Addr == TC_PRESET);

`ifdef TIMER_IRQ_STATUS_EN
  logic wr_status;
  assign wr_status = WE && (Addr == TC_STATUS);
`else
  logic wr_status;
  assign wr_status = 1'b0;
`endif

  // Only the explicit reload encoding auto-reloads; the spare encodings
  // behave as one-shot.
  always_comb begin
    reload_mode = 1'b0;
    case (ctrl_q.mode)
      TC_MODE_RELOAD:  reload_mode = 1'b1;
      TC_MODE_ONESHOT: reload_mode = 1'b0;
      default:         reload_mode = 1'b0;
    endcase
  end

  // Register writes and the FSM step are resolved together. The FSM acts on
  // the register values already in place (written on earlier edges), so a
  // write landing on this edge only influences the FSM from the next edge.
  always_comb begin
    ctrl_d   = wr_ctrl   ? tc_ctrl_t'(DIN[3:0]) : ctrl_q;
    preset_d = wr_preset ? DIN : preset_q;
    count_d  = count_q;
    state_d  = state_q;
    irq_set  = 1'b0;
    irq_clr  = wr_ctrl || wr_preset || wr_status;

    if (!ctrl_q.en) begin
      // Disabling aborts from any state; COUNT keeps its value.
      state_d = TC_IDLE;
    end else begin
      case (state_q)
        TC_IDLE: state_d = TC_LOAD;
        TC_LOAD: begin
          count_d = preset_q;
          state_d = TC_CNT;
        end
        TC_CNT: begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            state_d = TC_INT;
            irq_set = 1'b1;
          end
        end
        TC_INT: begin
          if (reload_mode) begin
            state_d = TC_LOAD;
            irq_clr = 1'b1;
          end else begin
            state_d = TC_IDLE;
            // A CPU write to CTRL on this edge takes precedence over the
            // hardware self-disable.
            if (!wr_ctrl) begin
              ctrl_d.en = 1'b0;
            end
          end
        end
        default: state_d = TC_IDLE;
      endcase
    end

    // Terminal count on the same edge as a clearing write: the set wins.
    if (irq_set) begin
      irq_pend_d = 1'b1;
    end else if (irq_clr) begin
      irq_pend_d = 1'b0;
    end else begin
      irq_pend_d = irq_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
      state_q    <= TC_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    DOUT = 32'd0;
    case (Addr)
      TC_CTRL:   DOUT = {28'd0, ctrl_q};
      TC_PRESET: DOUT = preset_q;
      TC_COUNT:  DOUT = count_q;
`ifdef TIMER_IRQ_STATUS_EN
      TC_STATUS: DOUT = {31'd0, irq_pend_q};
`else
      TC_STATUS: DOUT = 32'd0;
`endif
      default:   DOUT = 32'd0;
    endcase
  end

  assign IRQ = irq_pend_q && ctrl_q.im;

endmodule

`default_nettype wire
